// File: rtl/alu_issue_if.sv
// -----------------------------------------------------------------------------
// alu_issue_if
// Bundles the decode-side inputs, the execute-stage forwarding inputs and the
// registered issue outputs of alu_issue.
//
// Handshake: valid_in qualifies the decode fields in the cycle they are
// presented. stall holds every output register unchanged. flush replaces both
// the held and the incoming instruction with a bubble. valid_out marks the
// output registers as holding a live instruction.
//
// Modports
//   master : decode stage / testbench side (drives inputs, observes outputs)
//   slave  : alu_issue side (observes inputs, drives outputs)
//
// Signals
//   valid_in, opcode[6:0], funct3[2:0], funct7_b5       decode fields
//   rs1_addr, rs2_addr, rd_addr [4:0]                   register indices
//   rs1_data, rs2_data, imm [XLEN-1:0]                  operand sources
//   stall, flush                                        pipeline control
//   ex_result[XLEN-1:0], ex_rd[4:0], ex_reg_write       forwarding source
//   alu_op[3:0], in_a, in_b, rd_out, valid_out, illegal registered outputs
// -----------------------------------------------------------------------------
interface alu_issue_if #(
   parameter int XLEN = 32
);
   logic            valid_in;
   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic            funct7_b5;
   logic [4:0]      rs1_addr;
   logic [4:0]      rs2_addr;
   logic [4:0]      rd_addr;
   logic [XLEN-1:0] rs1_data;
   logic [XLEN-1:0] rs2_data;
   logic [XLEN-1:0] imm;
   logic            stall;
   logic            flush;
   logic [XLEN-1:0] ex_result;
   logic [4:0]      ex_rd;
   logic            ex_reg_write;
   logic [3:0]      alu_op;
   logic [XLEN-1:0] in_a;
   logic [XLEN-1:0] in_b;
   logic [4:0]      rd_out;
   logic            valid_out;
   logic            illegal;

   modport master (
      output valid_in, opcode, funct3, funct7_b5,
      output rs1_addr, rs2_addr, rd_addr,
      output rs1_data, rs2_data, imm,
      output stall, flush,
      output ex_result, ex_rd, ex_reg_write,
      input  alu_op, in_a, in_b, rd_out, valid_out, illegal
   );

   modport slave (
      input  valid_in, opcode, funct3, funct7_b5,
      input  rs1_addr, rs2_addr, rd_addr,
      input  rs1_data, rs2_data, imm,
      input  stall, flush,
      input  ex_result, ex_rd, ex_reg_write,
      output alu_op, in_a, in_b, rd_out, valid_out, illegal
   );
endinterface

// File: rtl/alu_issue.sv
// -----------------------------------------------------------------------------
// alu_issue
// Decode-to-execute issue register for a small RV32I ALU subset
// (ADD/SUB/AND/OR, ADDI/ANDI/ORI, load/store address add, branch compare SUB).
// All outputs are registered: one cycle latency, no combinational path from
// inputs to outputs.
//
// Ports
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (loads a bubble)
//   bus  : alu_issue_if.slave, see the interface header for the signal list
//
// Configuration macro
//   ALU_ISSUE_FWD_EN : when defined, rs1 and (when selected) rs2 are replaced
//                      by ex_result if the execute stage writes that register
//                      (ex_reg_write=1, ex_rd!=0, ex_rd==address). Forwarding
//                      is evaluated only when the register loads, never while
//                      a stall holds the outputs.
//
// No FSM: the block is a single pipeline register with a priority update
// (rst/flush > stall > load).
// -----------------------------------------------------------------------------
module alu_issue #(
   parameter int XLEN = 32
) (
   input  logic        clk,
   input  logic        rst,
   alu_issue_if.slave  bus
);

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [3:0] OP_AND = 4'b0000;
   localparam logic [3:0] OP_OR  = 4'b0001;
   localparam logic [3:0] OP_ADD = 4'b0010;
   localparam logic [3:0] OP_SUB = 4'b0110;
   localparam logic [3:0] OP_ILL = 4'b1110;

   // Decode results
   logic [3:0]      w_alu_op;
   logic            w_legal;
   logic            w_use_imm;
   logic            w_no_rd;
   logic [XLEN-1:0] w_rs1_val;
   logic [XLEN-1:0] w_rs2_val;
   logic [XLEN-1:0] w_in_b;

   // Output registers
   logic [3:0]      r_alu_op;
   logic [XLEN-1:0] r_in_a;
   logic [XLEN-1:0] r_in_b;
   logic [4:0]      r_rd_out;
   logic            r_valid_out;
   logic            r_illegal;

   always_comb begin
      w_alu_op  = OP_ILL;
      w_legal   = 1'b0;
      w_use_imm = 1'b0;
      w_no_rd   = 1'b0;
      case (bus.opcode)
         OPC_R: begin
            case (bus.funct3)
               3'b000: begin
                  w_legal  = 1'b1;
                  w_alu_op = bus.funct7_b5 ? OP_SUB : OP_ADD;
               end
               3'b111: begin
                  w_legal  = 1'b1;
                  w_alu_op = OP_AND;
               end
               3'b110: begin
                  w_legal  = 1'b1;
                  w_alu_op = OP_OR;
               end
               default: ;
            endcase
         end
         OPC_I: begin
            w_use_imm = 1'b1;
            case (bus.funct3)
               3'b000: begin
                  w_legal  = 1'b1;
                  w_alu_op = OP_ADD;
               end
               3'b111: begin
                  w_legal  = 1'b1;
                  w_alu_op = OP_AND;
               end
               3'b110: begin
                  w_legal  = 1'b1;
                  w_alu_op = OP_OR;
               end
               default: ;
            endcase
         end
         OPC_LOAD: begin
            // address generation: base + offset
            w_legal   = 1'b1;
            w_use_imm = 1'b1;
            w_alu_op  = OP_ADD;
         end
         OPC_STORE: begin
            // store writes no register, so the destination field is dropped
            w_legal   = 1'b1;
            w_use_imm = 1'b1;
            w_no_rd   = 1'b1;
            w_alu_op  = OP_ADD;
         end
         OPC_BRANCH: begin
            // branch compares rs1 - rs2 and writes no register
            w_legal   = 1'b1;
            w_no_rd   = 1'b1;
            w_alu_op  = OP_SUB;
         end
         default: ;
      endcase
   end

`ifdef ALU_ISSUE_FWD_EN
   logic w_fwd_ok;
   assign w_fwd_ok  = bus.ex_reg_write && (bus.ex_rd != 5'd0);
   assign w_rs1_val = (w_fwd_ok && (bus.ex_rd == bus.rs1_addr)) ? bus.ex_result : bus.rs1_data;
   assign w_rs2_val = (w_fwd_ok && (bus.ex_rd == bus.rs2_addr)) ? bus.ex_result : bus.rs2_data;
`else
   assign w_rs1_val = bus.rs1_data;
   assign w_rs2_val = bus.rs2_data;
   // Forwarding inputs are deliberately ignored in this build.
   logic w_unused_fwd;
   assign w_unused_fwd = ^{bus.ex_result, bus.ex_rd, bus.ex_reg_write,
                           bus.rs1_addr, bus.rs2_addr};
`endif

   assign w_in_b = w_use_imm ? bus.imm : w_rs2_val;

   // Priority: rst/flush bubble > stall hold > load (bubble when !valid_in).
   always_ff @(posedge clk) begin
      if (rst || bus.flush) begin
         r_alu_op    <= OP_AND;
         r_in_a      <= '0;
         r_in_b      <= '0;
         r_rd_out    <= 5'd0;
         r_valid_out <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (bus.stall) begin
         r_alu_op    <= r_alu_op;
         r_in_a      <= r_in_a;
         r_in_b      <= r_in_b;
         r_rd_out    <= r_rd_out;
         r_valid_out <= r_valid_out;
         r_illegal   <= r_illegal;
      end else if (!bus.valid_in) begin
         r_alu_op    <= OP_AND;
         r_in_a      <= '0;
         r_in_b      <= '0;
         r_rd_out    <= 5'd0;
         r_valid_out <= 1'b0;
         r_illegal   <= 1'b0;
      end else if (!w_legal) begin
         // Unsupported encoding still occupies the slot so execute can trap.
         r_alu_op    <= OP_ILL;
         r_in_a      <= '0;
         r_in_b      <= '0;
         r_rd_out    <= 5'd0;
         r_valid_out <= 1'b1;
         r_illegal   <= 1'b1;
      end else begin
         r_alu_op    <= w_alu_op;
         r_in_a      <= w_rs1_val;
         r_in_b      <= w_in_b;
         r_rd_out    <= w_no_rd ? 5'd0 : bus.rd_addr;
         r_valid_out <= 1'b1;
         r_illegal   <= 1'b0;
      end
   end

   assign bus.alu_op    = r_alu_op;
   assign bus.in_a      = r_in_a;
   assign bus.in_b      = r_in_b;
   assign bus.rd_out    = r_rd_out;
   assign bus.valid_out = r_valid_out;
   assign bus.illegal   = r_illegal;

endmodule

// File: tb/tb_alu_issue.sv
// -----------------------------------------------------------------------------
// tb_alu_issue
// Directed-vector bench for alu_issue. Expected values are hand-computed
// constants. Build with +define+ALU_ISSUE_FWD_EN to exercise forwarding.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_alu_issue;

   localparam int XLEN = 32;

   localparam logic [6:0] OPC_R      = 7'b0110011;
   localparam logic [6:0] OPC_I      = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   alu_issue_if #(.XLEN(XLEN)) bus ();

   alu_issue #(.XLEN(XLEN)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // advance one edge and settle before sampling
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [6:0] opc, input logic [2:0] f3,
                        input logic f7, input logic [4:0] a1, input logic [4:0] a2,
                        input logic [4:0] rd, input logic [31:0] d1,
                        input logic [31:0] d2, input logic [31:0] im);
      bus.valid_in  = v;
      bus.opcode    = opc;
      bus.funct3    = f3;
      bus.funct7_b5 = f7;
      bus.rs1_addr  = a1;
      bus.rs2_addr  = a2;
      bus.rd_addr   = rd;
      bus.rs1_data  = d1;
      bus.rs2_data  = d2;
      bus.imm       = im;
   endtask

   task automatic expect_out(input string tag, input logic [3:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd,
                             input logic v, input logic ill);
      check({tag, ".alu_op"},    {28'd0, bus.alu_op},    {28'd0, op});
      check({tag, ".in_a"},      bus.in_a,               a);
      check({tag, ".in_b"},      bus.in_b,               b);
      check({tag, ".rd_out"},    {27'd0, bus.rd_out},    {27'd0, rd});
      check({tag, ".valid_out"}, {31'd0, bus.valid_out}, {31'd0, v});
      check({tag, ".illegal"},   {31'd0, bus.illegal},   {31'd0, ill});
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      bus.stall        = 1'b0;
      bus.flush        = 1'b0;
      bus.ex_result    = 32'h0;
      bus.ex_rd        = 5'd0;
      bus.ex_reg_write = 1'b0;
      // a live instruction during reset must still give a bubble
      drive(1'b1, OPC_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'd0);
      cycle();
      cycle();
      expect_out("reset", 4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      rst = 1'b0;

      // ADD x3,x1,x2
      drive(1'b1, OPC_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'hdead);
      cycle();
      expect_out("add", 4'b0010, 32'd5, 32'd6, 5'd3, 1'b1, 1'b0);

      // SUB
      drive(1'b1, OPC_R, 3'b000, 1'b1, 5'd1, 5'd2, 5'd4, 32'h80000000, 32'd1, 32'h0);
      cycle();
      expect_out("sub", 4'b0110, 32'h80000000, 32'd1, 5'd4, 1'b1, 1'b0);

      // AND / OR R-type
      drive(1'b1, OPC_R, 3'b111, 1'b0, 5'd5, 5'd6, 5'd9, 32'hf0f0aaaa, 32'h0ff05555, 32'h0);
      cycle();
      expect_out("and", 4'b0000, 32'hf0f0aaaa, 32'h0ff05555, 5'd9, 1'b1, 1'b0);
      drive(1'b1, OPC_R, 3'b110, 1'b0, 5'd5, 5'd6, 5'd10, 32'h11, 32'h22, 32'h0);
      cycle();
      expect_out("or", 4'b0001, 32'h11, 32'h22, 5'd10, 1'b1, 1'b0);

      // ADDI / ANDI
      drive(1'b1, OPC_I, 3'b000, 1'b0, 5'd1, 5'd2, 5'd11, 32'd100, 32'd7, 32'hfffffffc);
      cycle();
      expect_out("addi", 4'b0010, 32'd100, 32'hfffffffc, 5'd11, 1'b1, 1'b0);
      drive(1'b1, OPC_I, 3'b111, 1'b1, 5'd1, 5'd2, 5'd12, 32'h1234ffff, 32'd7, 32'h000000ff);
      cycle();
      expect_out("andi", 4'b0000, 32'h1234ffff, 32'h000000ff, 5'd12, 1'b1, 1'b0);

      // load / store / branch
      drive(1'b1, OPC_LOAD, 3'b010, 1'b0, 5'd2, 5'd3, 5'd13, 32'h1000, 32'h9, 32'h10);
      cycle();
      expect_out("load", 4'b0010, 32'h1000, 32'h10, 5'd13, 1'b1, 1'b0);
      drive(1'b1, OPC_STORE, 3'b010, 1'b0, 5'd2, 5'd3, 5'd14, 32'h2000, 32'h9, 32'h8);
      cycle();
      expect_out("store", 4'b0010, 32'h2000, 32'h8, 5'd0, 1'b1, 1'b0);
      drive(1'b1, OPC_BRANCH, 3'b001, 1'b0, 5'd2, 5'd3, 5'd15, 32'd40, 32'd30, 32'h44);
      cycle();
      expect_out("branch", 4'b0110, 32'd40, 32'd30, 5'd0, 1'b1, 1'b0);

      // illegal funct3
      drive(1'b1, OPC_R, 3'b001, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'h0);
      cycle();
      check("illegal.alu_op",    {28'd0, bus.alu_op},    32'he);
      check("illegal.in_a",      bus.in_a,               32'h0);
      check("illegal.in_b",      bus.in_b,               32'h0);
      check("illegal.valid_out", {31'd0, bus.valid_out}, 32'h1);
      check("illegal.illegal",   {31'd0, bus.illegal},   32'h1);

      // valid_in low loads a bubble
      drive(1'b0, OPC_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd6, 32'h0);
      cycle();
      expect_out("novalid", 4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);

      // ORI then stall 3 cycles with changing inputs
      drive(1'b1, OPC_I, 3'b110, 1'b0, 5'd1, 5'd2, 5'd7, 32'h0f0f0f0f, 32'd0, 32'hffff0000);
      cycle();
      expect_out("ori", 4'b0001, 32'h0f0f0f0f, 32'hffff0000, 5'd7, 1'b1, 1'b0);
      bus.stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, OPC_R, 3'b000, 1'b1, 5'd3, 5'd4, 5'd20 + 5'(i), 32'd1 + i, 32'd99, 32'h0);
         cycle();
         expect_out($sformatf("stall%0d", i), 4'b0001, 32'h0f0f0f0f, 32'hffff0000, 5'd7, 1'b1, 1'b0);
      end

      // flush wins over stall
      bus.flush = 1'b1;
      cycle();
      expect_out("flush_stall", 4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      bus.flush = 1'b0;
      bus.stall = 1'b0;

      // reset during a stall drops the held instruction
      drive(1'b1, OPC_R, 3'b000, 1'b0, 5'd1, 5'd2, 5'd8, 32'd50, 32'd60, 32'h0);
      cycle();
      expect_out("pre_rst", 4'b0010, 32'd50, 32'd60, 5'd8, 1'b1, 1'b0);
      bus.stall = 1'b1;
      rst = 1'b1;
      cycle();
      expect_out("rst_stall", 4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      rst = 1'b0;
      cycle();
      expect_out("post_rst_hold", 4'b0000, 32'h0, 32'h0, 5'd0, 1'b0, 1'b0);
      bus.stall = 1'b0;
      cycle();
      expect_out("post_rst_load", 4'b0010, 32'd50, 32'd60, 5'd8, 1'b1, 1'b0);

      // forwarding of rs1 from execute
      drive(1'b1, OPC_R, 3'b000, 1'b0, 5'd4, 5'd5, 5'd6, 32'h0, 32'd3, 32'h0);
      bus.ex_result    = 32'h1234;
      bus.ex_rd        = 5'd4;
      bus.ex_reg_write = 1'b1;
      cycle();
`ifdef ALU_ISSUE_FWD_EN
      check("fwd_rs1.in_a", bus.in_a, 32'h1234);
`else
      check("nofwd_rs1.in_a", bus.in_a, 32'h0);
`endif
      check("fwd_rs1.in_b", bus.in_b, 32'd3);
      bus.ex_rd = 5'd0;
      drive(1'b1, OPC_R, 3'b000, 1'b0, 5'd0, 5'd5, 5'd6, 32'h0, 32'd3, 32'h0);
      cycle();
      check("fwd_x0.in_a", bus.in_a, 32'h0);
      bus.ex_reg_write = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
ALU_ISSUE -- requirements
Module: alu_issue

Interface
REQ-001 Parameter: XLEN, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  input  1  rising-edge clock, single clock domain.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Port: valid_in  input  1  decode stage presents an instruction this cycle.
REQ-005 Port: opcode  input  7  instruction bits [6:0].
REQ-006 Port: funct3  input  3  instruction bits [14:12].
REQ-007 Port: funct7_b5  input  1  instruction bit 30.
REQ-008 Port: rs1_addr, rs2_addr, rd_addr  input  5 each  register indices.
REQ-009 Port: rs1_data, rs2_data, imm  input  XLEN each  register-file reads and sign-extended immediate.
REQ-010 Port: stall  input  1  execute stage cannot accept; hold outputs.
REQ-011 Port: flush  input  1  discard the held and incoming instruction.
REQ-012 Port: ex_result  input  XLEN  current ALU result (forwarding source).
REQ-013 Port: ex_rd  input  5  destination of the instruction in execute.
REQ-014 Port: ex_reg_write  input  1  instruction in execute writes ex_rd.
REQ-015 Port: alu_op  output  4  registered ALU op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB.
REQ-016 Port: in_a, in_b  output  XLEN each  registered ALU operands.
REQ-017 Port: rd_out  output  5  registered destination index.
REQ-018 Port: valid_out  output  1  outputs hold a live instruction.
REQ-019 Port: illegal  output  1  held instruction is unsupported; registered.

Function
REQ-020 Decode: opcode 0110011 with funct3 000 SHALL give ADD (funct7_b5=0) or SUB (funct7_b5=1); funct3 111 AND; 110 OR; in_b=rs2.
REQ-021 Decode: opcode 0010011 funct3 000/111/110 SHALL give ADD/AND/OR with in_b=imm.
REQ-022 Decode: opcode 0000011 or 0100011 SHALL give ADD with in_b=imm; opcode 1100011 SHALL give SUB with in_b=rs2.
REQ-023 Any other opcode/funct combination SHALL load alu_op=1110, in_a=in_b=0, illegal=1, valid_out=1.
REQ-024 in_a SHALL be rs1 operand in all legal cases.
REQ-025 Register update on each clk edge: flush -> bubble; else stall -> hold all outputs; else load decoded values with valid_out=valid_in.
REQ-026 Bubble: alu_op=0000, in_a=in_b=0, rd_out=0, valid_out=0, illegal=0.
REQ-027 flush SHALL take priority over stall when both are high.
REQ-028 valid_in=0 with no stall/flush SHALL load a bubble.
REQ-029 Latency: exactly one cycle from inputs to registered outputs; no combinational path from inputs to outputs.
REQ-030 Store/branch opcodes SHALL force rd_out=0.

Reset
REQ-031 rst high at a clk edge SHALL load the bubble (REQ-026), overriding flush, stall and valid_in.
REQ-032 rst asserted mid-stall SHALL discard the held instruction; first cycle after rst release SHALL behave per REQ-025.

Configuration
REQ-033 Macro ALU_ISSUE_FWD_EN: when defined, rs1 (and rs2 when selected) operand SHALL be replaced by ex_result if its address equals ex_rd, ex_reg_write=1, and ex_rd!=0; forwarding is evaluated only on load cycles, never on stall-hold.
REQ-034 Without ALU_ISSUE_FWD_EN: operands come from rs1_data/rs2_data only; ex_result, ex_rd, ex_reg_write are ignored.

Verification
REQ-035 ADD x3,x1,x2 with rs1=5, rs2=6, valid_in=1 -> next cycle alu_op=0010, in_a=5, in_b=6, rd_out=3, valid_out=1.
REQ-036 SUB (funct7_b5=1) rs1=0x80000000, rs2=1 -> alu_op=0110, in_a=0x80000000, in_b=1.
REQ-037 ORI rs1=0x0f0f0f0f, imm=0xffff0000, then stall=1 for 3 cycles with new inputs -> outputs unchanged 3 cycles, alu_op=0001, in_b=0xffff0000.
REQ-038 stall=1 and flush=1 together -> next cycle valid_out=0, alu_op=0000, in_a=in_b=0.
REQ-039 opcode 0110011 funct3 001 -> alu_op=1110, illegal=1, in_a=in_b=0.
REQ-040 FWD_EN: rs1_addr=4, ex_rd=4, ex_reg_write=1, ex_result=0x1234, rs1_data=0 -> in_a=0x1234; same with ex_rd=0 -> in_a=0.
